encoder_period_counter: RTL and testbench

// - Measures enabled clk_1 cycles between consecutive rising edges of the motor encoder pulse.
// - Publishes the period as speed_cnt, which is the divisor input of the downstream rpm speed computation.
// - Never presents 0 to the downstream divider.
// - Sits between the encoder pin and the speed computation stage.

---
 rtl/speed_pkg.sv | 24 ++
 rtl/encoder_input_filter.sv | 72 +++++++
 rtl/encoder_period_counter.sv | 123 ++++++++++++
 tb/tb_encoder_period_counter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Shared definitions for the encoder speed path: widths, the standstill
// constant understood by the rpm divider, and the period FSM state type.
package speed_pkg;

  // Default width of the period counter and of the published period.
  localparam int CNT_WIDTH_DEFAULT = 32;

  // Default number of consecutive equal samples needed to accept a level change.
  localparam int FILT_LEN_DEFAULT = 4;

  // Width of the glitch filter run counter; holds FILT_LEN values up to 15.
  localparam int FILT_CNT_WIDTH = 4;

  // Standstill timeout. The speed computation treats this period as "stopped".
  localparam logic [31:0] MAX_CNT_DEFAULT = 32'd50_000_000;

  // Period measurement state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } enc_state_t;

endpackage

// File: rtl/encoder_input_filter.sv
// encoder_input_filter: brings the raw encoder pin into the clk_1 domain,
// rejects pulses shorter than FILT_LEN enabled samples and flags each
// accepted 0->1 change of the filtered level with a one-enabled-cycle rise.
module encoder_input_filter
  import speed_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
  input  logic clk_1,
  input  logic clr,
  input  logic ce_1,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [FILT_CNT_WIDTH-1:0] RUN_LAST = FILT_CNT_WIDTH'(FILT_LEN - 1);
  localparam logic [FILT_CNT_WIDTH-1:0] RUN_ONE  = FILT_CNT_WIDTH'(1);

  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic                      level_q, level_d;
  logic                      rise_q, rise_d;
  logic [FILT_CNT_WIDTH-1:0] run_q, run_d;

  // Synchronize, count how long the synchronized input has disagreed with the
  // accepted level, and flip the level once that run reaches FILT_LEN samples.
  always_comb begin
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    level_d = level_q;
    rise_d  = rise_q;
    run_d   = run_q;
    if (ce_1) begin
      sync1_d = din;
      sync2_d = sync1_q;
      rise_d  = 1'b0;
      if (sync2_q != level_q) begin
        if (run_q == RUN_LAST) begin
          level_d = sync2_q;
          rise_d  = sync2_q;
          run_d   = '0;
        end else begin
          run_d = run_q + RUN_ONE;
        end
      end else begin
        run_d = '0;
      end
    end
  end

  // Filter registers; everything holds while ce_1 is low.
  always_ff @(posedge clk_1) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      run_q   <= run_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/encoder_period_counter.sv
// encoder_period_counter: counts enabled clk_1 cycles between filtered
// encoder rising edges and publishes the period as the rpm divisor. A missing
// edge for MAX_CNT cycles reports MAX_CNT with stalled set; zero is never shown.
module encoder_period_counter
  import speed_pkg::*;
#(
  parameter int                   CNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int                   FILT_LEN  = FILT_LEN_DEFAULT,
  parameter logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_CNT_DEFAULT)
) (
  input  logic                 clk_1,
  input  logic                 clr,
  input  logic                 ce_1,
  input  logic                 enc_in,
  output logic [CNT_WIDTH-1:0] speed_cnt,
  output logic                 cnt_valid,
  output logic                 stalled
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic enc_level;
  logic enc_rise;

  enc_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_WIDTH-1:0] speed_cnt_q, speed_cnt_d;
  logic                 cnt_valid_q, cnt_valid_d;
  logic                 stalled_q, stalled_d;

  encoder_input_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk_1 (clk_1),
    .clr   (clr),
    .ce_1  (ce_1),
    .din   (enc_in),
    .level (enc_level),
    .rise  (enc_rise)
  );

  // Period FSM: start counting on the first edge, report on each later edge,
  // and report the standstill value once when the count saturates.
  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    speed_cnt_d = speed_cnt_q;
    stalled_d   = stalled_q;
    cnt_valid_d = cnt_valid_q;
    if (ce_1) begin
      cnt_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (enc_rise) begin
            per_cnt_d = CNT_ONE;
            state_d   = MEASURE;
          end
        end
        MEASURE: begin
          if (enc_rise) begin
            speed_cnt_d = per_cnt_q;
            cnt_valid_d = 1'b1;
            stalled_d   = 1'b0;
            per_cnt_d   = CNT_ONE;
          end else if (per_cnt_q >= MAX_CNT) begin
            speed_cnt_d = MAX_CNT;
            cnt_valid_d = 1'b1;
            stalled_d   = 1'b1;
            per_cnt_d   = MAX_CNT;
            state_d     = STALLED;
          end else begin
            per_cnt_d = per_cnt_q + CNT_ONE;
          end
        end
        STALLED: begin
          if (enc_rise) begin
            per_cnt_d = CNT_ONE;
            state_d   = MEASURE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter and output registers; clr wins over ce_1.
  always_ff @(posedge clk_1) begin
    if (clr) begin
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      speed_cnt_q <= MAX_CNT;
      cnt_valid_q <= 1'b0;
      stalled_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      speed_cnt_q <= speed_cnt_d;
      cnt_valid_q <= cnt_valid_d;
      stalled_q   <= stalled_d;
    end
  end

  // The valid flop holds through disabled cycles like every other register,
  // so the pulse is masked by ce_1 to keep it from showing while disabled.
  assign cnt_valid = cnt_valid_q & ce_1;
  assign speed_cnt = speed_cnt_q;
  assign stalled   = stalled_q;

  // An accepted rise always comes with a high filtered level.
  a_rise_level : assert property (@(posedge clk_1) disable iff (clr)
    enc_rise |-> enc_level);

  // The divisor handed downstream is never zero.
  a_speed_nonzero : assert property (@(posedge clk_1) disable iff (clr)
    speed_cnt_q != '0);

  // The period counter saturates and never runs past the timeout.
  a_per_cnt_sat : assert property (@(posedge clk_1) disable iff (clr)
    per_cnt_q <= MAX_CNT);

endmodule

// File: tb/tb_encoder_period_counter.sv
// Bench for encoder_period_counter: directed scenarios plus a randomized
// section, compared every cycle against an event-time reference model.
module tb_encoder_period_counter;

  localparam int TB_CNT_WIDTH = speed_pkg::CNT_WIDTH_DEFAULT;
  localparam int TB_FILT_LEN  = 4;
  localparam int TB_MAX_CNT   = 5000;

  logic                    clk_1 = 1'b0;
  logic                    clr;
  logic                    ce_1;
  logic                    enc_in;
  logic [TB_CNT_WIDTH-1:0] speed_cnt;
  logic                    cnt_valid;
  logic                    stalled;

  int checks = 0;
  int errors = 0;

  // Reference model state: raw samples at enabled edges, filtered level,
  // pending event, time of last event and expected registered outputs.
  bit     raw_hist[$];
  bit     m_level;
  bit     m_pending;
  bit     m_measuring;
  longint m_cycle;
  longint m_last;
  longint m_speed;
  bit     m_valid;
  bit     m_stalled;

  // Observed pulse statistics for directed scenario checks.
  int     pulse_cnt;
  int     stall_pulse_cnt;
  int     bad_valid_cnt;
  longint first_speed;
  longint last_speed;
  bit     last_stalled;

  int ce_mode;
  bit ce_toggle;

  always #5 clk_1 = ~clk_1;

  encoder_period_counter #(
    .CNT_WIDTH (TB_CNT_WIDTH),
    .FILT_LEN  (TB_FILT_LEN),
    .MAX_CNT   (32'(TB_MAX_CNT))
  ) dut (
    .clk_1     (clk_1),
    .clr       (clr),
    .ce_1      (ce_1),
    .enc_in    (enc_in),
    .speed_cnt (speed_cnt),
    .cnt_valid (cnt_valid),
    .stalled   (stalled)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    raw_hist.delete();
    m_level     = 1'b0;
    m_pending   = 1'b0;
    m_measuring = 1'b0;
    m_cycle     = 0;
    m_last      = 0;
    m_speed     = TB_MAX_CNT;
    m_valid     = 1'b0;
    m_stalled   = 1'b1;
  endfunction

  // One clk_1 edge of the reference: periods are differences of event times,
  // the filter flips when the last TB_FILT_LEN synchronized samples (raw
  // samples two enabled edges old) all disagree with the current level.
  function automatic void modelStep(input bit ce, input bit enc, input bit rst);
    bit flip;
    bit smp;
    int idx;
    if (rst) begin
      modelReset();
    end else if (ce) begin
      m_cycle++;
      m_valid = 1'b0;
      if (m_pending) begin
        if (m_measuring) begin
          m_speed   = m_cycle - m_last;
          m_valid   = 1'b1;
          m_stalled = 1'b0;
        end
        m_measuring = 1'b1;
        m_last      = m_cycle;
      end else if (m_measuring && (m_cycle - m_last) == TB_MAX_CNT) begin
        m_speed     = TB_MAX_CNT;
        m_valid     = 1'b1;
        m_stalled   = 1'b1;
        m_measuring = 1'b0;
      end
      flip = 1'b1;
      for (int j = 0; j < TB_FILT_LEN; j++) begin
        idx = raw_hist.size() - 2 - j;
        smp = (idx >= 0) ? raw_hist[idx] : 1'b0;
        if (smp == m_level) flip = 1'b0;
      end
      m_pending = flip && !m_level;
      if (flip) m_level = !m_level;
      raw_hist.push_back(enc);
      if (raw_hist.size() > TB_FILT_LEN + 4) void'(raw_hist.pop_front());
    end
  endfunction

  function automatic bit nextCe();
    bit ce;
    case (ce_mode)
      1:       begin ce_toggle = !ce_toggle; ce = ce_toggle; end
      2:       ce = ($urandom_range(0, 4) != 0);
      default: ce = 1'b1;
    endcase
    return ce;
  endfunction

  function automatic void resetCounts();
    pulse_cnt       = 0;
    stall_pulse_cnt = 0;
    bad_valid_cnt   = 0;
    first_speed     = 0;
    last_speed      = 0;
    last_stalled    = 1'b0;
  endfunction

  // Drive one cycle on the falling edge, compare outputs, advance the model.
  task automatic applyStimulus(input bit ce, input bit enc, input bit rst);
    @(negedge clk_1);
    ce_1   = ce;
    enc_in = enc;
    clr    = rst;
    #1;
    checkOutput("speed_cnt", speed_cnt, m_speed);
    checkOutput("stalled", stalled, m_stalled);
    checkOutput("cnt_valid", cnt_valid, m_valid & ce);
    if (cnt_valid === 1'b1) begin
      pulse_cnt++;
      if (pulse_cnt == 1) first_speed = speed_cnt;
      last_speed   = speed_cnt;
      last_stalled = stalled;
      if (stalled) stall_pulse_cnt++;
      if (!ce) bad_valid_cnt++;
    end
    modelStep(ce, enc, rst);
  endtask

  task automatic runLevel(input int n, input bit enc);
    for (int i = 0; i < n; i++) applyStimulus(nextCe(), enc, 1'b0);
  endtask

  task automatic pulseClr();
    applyStimulus(1'b1, 1'b0, 1'b1);
    resetCounts();
  endtask

  initial begin
    clr       = 1'b1;
    ce_1      = 1'b1;
    enc_in    = 1'b0;
    ce_mode   = 0;
    ce_toggle = 1'b0;
    modelReset();
    resetCounts();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst_speed", speed_cnt, TB_MAX_CNT);
    checkOutput("rst_stalled", stalled, 1);
    checkOutput("rst_valid", cnt_valid, 0);

    $display("[TB] square wave, period 1000");
    resetCounts();
    for (int p = 0; p < 5; p++) begin
      runLevel(500, 1'b1);
      runLevel(500, 1'b0);
    end
    checkOutput("sq_pulses", pulse_cnt, 4);
    checkOutput("sq_speed", last_speed, 1000);
    checkOutput("sq_stalled", last_stalled, 0);

    $display("[TB] stop after two edges, timeout, restart");
    pulseClr();
    runLevel(400, 1'b1);
    runLevel(400, 1'b0);
    runLevel(400, 1'b1);
    runLevel(5100, 1'b0);
    checkOutput("stop_first_speed", first_speed, 800);
    checkOutput("stop_pulses", pulse_cnt, 2);
    checkOutput("stop_timeout_speed", last_speed, TB_MAX_CNT);
    checkOutput("stop_timeout_stalled", last_stalled, 1);
    runLevel(600, 1'b0);
    checkOutput("stop_quiet", pulse_cnt, 2);
    resetCounts();
    runLevel(150, 1'b1);
    runLevel(150, 1'b0);
    runLevel(150, 1'b1);
    runLevel(150, 1'b0);
    checkOutput("restart_pulses", pulse_cnt, 1);
    checkOutput("restart_speed", last_speed, 300);
    checkOutput("restart_stalled", last_stalled, 0);

    $display("[TB] glitch rejection");
    pulseClr();
    runLevel(100, 1'b1);
    runLevel(100, 1'b0);
    for (int g = 0; g < 10; g++) begin
      runLevel(3, 1'b1);
      runLevel(10, 1'b0);
    end
    checkOutput("glitch_pulses", pulse_cnt, 0);
    runLevel(4, 1'b1);
    runLevel(50, 1'b0);
    checkOutput("glitch4_pulses", pulse_cnt, 1);
    checkOutput("glitch4_speed", last_speed, 330);

    $display("[TB] ce_1 toggling, enc period 2000");
    pulseClr();
    ce_mode = 1;
    for (int p = 0; p < 3; p++) begin
      runLevel(1000, 1'b1);
      runLevel(1000, 1'b0);
    end
    ce_mode = 0;
    checkOutput("ce_pulses", pulse_cnt, 2);
    checkOutput("ce_speed", last_speed, 1000);
    checkOutput("ce_valid_while_off", bad_valid_cnt, 0);

    $display("[TB] clr mid-period");
    pulseClr();
    runLevel(200, 1'b1);
    runLevel(800, 1'b0);
    runLevel(200, 1'b1);
    runLevel(200, 1'b0);
    checkOutput("pre_clr_speed", last_speed, 1000);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clr_speed", speed_cnt, TB_MAX_CNT);
    checkOutput("clr_stalled", stalled, 1);
    checkOutput("clr_valid", cnt_valid, 0);
    resetCounts();
    runLevel(598, 1'b0);
    for (int p = 0; p < 2; p++) begin
      runLevel(200, 1'b1);
      runLevel(800, 1'b0);
    end
    checkOutput("post_clr_pulses", pulse_cnt, 1);
    checkOutput("post_clr_speed", last_speed, 1000);
    checkOutput("post_clr_stalled", last_stalled, 0);

    $display("[TB] events exactly MAX_CNT apart");
    pulseClr();
    for (int p = 0; p < 4; p++) begin
      runLevel(100, 1'b1);
      runLevel(TB_MAX_CNT - 100, 1'b0);
    end
    checkOutput("max_pulses", pulse_cnt, 3);
    checkOutput("max_speed", last_speed, TB_MAX_CNT);
    checkOutput("max_stalled", last_stalled, 0);
    checkOutput("max_no_timeout", stall_pulse_cnt, 0);

    $display("[TB] randomized stimulus");
    pulseClr();
    ce_mode = 2;
    for (int r = 0; r < 150; r++) begin
      bit lvl;
      lvl = 1'($urandom_range(0, 1));
      runLevel(int'($urandom_range(1, 60)), lvl);
      if ($urandom_range(0, 99) == 0) applyStimulus(1'b1, lvl, 1'b1);
    end
    ce_mode = 0;
    runLevel(50, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
